// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staggered multi-domain reset release with run counting, halt and timeout
// Domains are held for HOLD_CYCLES, then released lowest bit first, STAGGER edges apart.
module rst_sequencer #(
  parameter int HOLD_CYCLES = 25,
  parameter int CHANNELS    = 4,
  parameter int STAGGER     = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sw_rst_req,
  input  logic                halt_in,
  output logic [CHANNELS-1:0] rst_out,
  output logic                rdy_out,
  output logic                done_out,
  output logic                timeout_out,
  output logic [31:0]         run_cnt
);

  typedef enum logic [1:0] {S_HOLD, S_STAGGER, S_RUN, S_DONE} state_t;

  localparam logic [31:0] HOLD_C      = 32'(HOLD_CYCLES);
  localparam logic [31:0] STG_C       = 32'(STAGGER);
  localparam logic [31:0] TMO_C       = 32'(TIMEOUT);
  localparam logic [4:0]  LAST_CH     = 5'(CHANNELS - 1);
  localparam bit          ALL_AT_ONCE = (CHANNELS == 1) || (STAGGER == 0);

  state_t              r_state, w_state_n;
  logic [31:0]         r_hold_cnt, w_hold_cnt_n;
  logic [31:0]         r_stg_cnt, w_stg_cnt_n;
  logic [4:0]          r_chan, w_chan_n;
  logic [CHANNELS-1:0] r_rst, w_rst_n;
  logic                r_rdy, w_rdy_n;
  logic                r_done, w_done_n;
  logic                r_tmo, w_tmo_n;
  logic [31:0]         r_run_cnt, w_run_cnt_n;
  logic [CHANNELS-1:0] w_clr_mask;
  logic [31:0]         w_hold_inc;
  logic [31:0]         w_stg_inc;

  assign w_hold_inc = r_hold_cnt + 32'd1;
  assign w_stg_inc  = r_stg_cnt + 32'd1;

  // One-hot mask of the channel due for release next.
  always_comb begin
    w_clr_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_clr_mask[i] = (5'(i) == r_chan);
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_hold_cnt_n = r_hold_cnt;
    w_stg_cnt_n  = r_stg_cnt;
    w_chan_n     = r_chan;
    w_rst_n      = r_rst;
    w_rdy_n      = r_rdy;
    w_done_n     = r_done;
    w_tmo_n      = r_tmo;
    w_run_cnt_n  = r_run_cnt;

    case (r_state)
      S_HOLD: begin
        w_hold_cnt_n = w_hold_inc;
        if (w_hold_inc == HOLD_C) begin
          if (ALL_AT_ONCE) begin
            w_rst_n   = '0;
            w_rdy_n   = 1'b1;
            w_state_n = S_RUN;
          end else begin
            w_rst_n     = r_rst & ~w_clr_mask;
            w_chan_n    = 5'd1;
            w_stg_cnt_n = 32'd0;
            w_state_n   = S_STAGGER;
          end
        end
      end
      S_STAGGER: begin
        if (w_stg_inc == STG_C) begin
          w_rst_n     = r_rst & ~w_clr_mask;
          w_stg_cnt_n = 32'd0;
          if (r_chan == LAST_CH) begin
            w_rdy_n   = 1'b1;
            w_state_n = S_RUN;
          end else begin
            w_chan_n = r_chan + 5'd1;
          end
        end else begin
          w_stg_cnt_n = w_stg_inc;
        end
      end
      S_RUN: begin
        // Halt outranks timeout when both land on the same edge.
        if (halt_in) begin
          w_done_n  = 1'b1;
          w_rdy_n   = 1'b0;
          w_state_n = S_DONE;
        end else if ((TIMEOUT != 0) && (r_run_cnt == TMO_C - 32'd1)) begin
          w_run_cnt_n = TMO_C;
          w_rst_n     = '1;
          w_done_n    = 1'b1;
          w_tmo_n     = 1'b1;
          w_rdy_n     = 1'b0;
          w_state_n   = S_DONE;
        end else if (r_run_cnt != 32'hFFFF_FFFF) begin
          w_run_cnt_n = r_run_cnt + 32'd1;
        end
      end
      S_DONE: begin
        w_state_n = S_DONE;
      end
      default: begin
        w_state_n = S_HOLD;
      end
    endcase

    if (sw_rst_req) begin
      w_state_n    = S_HOLD;
      w_hold_cnt_n = 32'd0;
      w_stg_cnt_n  = 32'd0;
      w_chan_n     = 5'd0;
      w_rst_n      = '1;
      w_rdy_n      = 1'b0;
      w_done_n     = 1'b0;
      w_tmo_n      = 1'b0;
      w_run_cnt_n  = 32'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= 32'd0;
      r_stg_cnt  <= 32'd0;
      r_chan     <= 5'd0;
      r_rst      <= '1;
      r_rdy      <= 1'b0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
      r_run_cnt  <= 32'd0;
    end else begin
      r_state    <= w_state_n;
      r_hold_cnt <= w_hold_cnt_n;
      r_stg_cnt  <= w_stg_cnt_n;
      r_chan     <= w_chan_n;
      r_rst      <= w_rst_n;
      r_rdy      <= w_rdy_n;
      r_done     <= w_done_n;
      r_tmo      <= w_tmo_n;
      r_run_cnt  <= w_run_cnt_n;
    end
  end

  assign rst_out     = r_rst;
  assign rdy_out     = r_rdy;
  assign done_out    = r_done;
  assign timeout_out = r_tmo;
  assign run_cnt     = r_run_cnt;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 25, cycles all domains stay in reset after reset release (legal >= 1).
REQ-002 Parameter CHANNELS, default 4, number of independent reset domains (legal 1..16).
REQ-003 Parameter STAGGER, default 2, cycles between successive channel releases (0 = release all together).
REQ-004 Parameter TIMEOUT, default 0, RUN-cycle limit (0 = disabled).
REQ-005 clk_in  input  1  single clock, all logic on rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 sw_rst_req  input  1  one-cycle request to re-run the reset sequence.
REQ-008 halt_in  input  1  program-end indication from the core.
REQ-009 rst_out  output  CHANNELS  per-domain active-high reset; bit 0 released first.
REQ-010 rdy_out  output  1  high while all domains are released and state is RUN.
REQ-011 done_out  output  1  high in DONE state.
REQ-012 timeout_out  output  1  sticky; high when DONE was entered by timeout.
REQ-013 run_cnt  output  32  count of RUN cycles since the last release completed.

Function
REQ-014 FSM states SHALL be HOLD, STAGGER, RUN, DONE; all outputs SHALL be registered.
REQ-015 HOLD: counter increments each edge; on the edge where it reaches HOLD_CYCLES, rst_out[0] SHALL clear and state SHALL go to STAGGER (or RUN if CHANNELS=1 or STAGGER=0, clearing all bits).
REQ-016 STAGGER: rst_out[i] SHALL clear exactly STAGGER*i edges after rst_out[0] cleared; on the edge clearing the last bit, state SHALL go to RUN and rdy_out SHALL rise.
REQ-017 Released bits SHALL never re-assert except via rst_in, sw_rst_req, or timeout.
REQ-018 RUN: run_cnt SHALL increment by 1 per edge, saturating at 32'hFFFFFFFF.
REQ-019 RUN with halt_in=1: next state DONE, done_out=1, rdy_out=0, run_cnt not incremented on that edge and frozen, rst_out stays all-zero.
REQ-020 RUN with TIMEOUT!=0: on the edge where run_cnt would become TIMEOUT, run_cnt SHALL load TIMEOUT, state SHALL go to DONE, timeout_out=1, rst_out SHALL become all-ones.
REQ-021 halt_in and timeout on the same edge: halt SHALL win; timeout_out stays 0.
REQ-022 sw_rst_req=1 in any state: next edge state HOLD, hold counter 0, rst_out all-ones, rdy_out=0, done_out=0, timeout_out=0, run_cnt=0.
REQ-023 sw_rst_req SHALL take priority over halt_in and timeout on the same edge.
REQ-024 halt_in SHALL be ignored outside RUN.
REQ-025 DONE SHALL persist until rst_in or sw_rst_req.

Reset
REQ-026 rst_in=1 SHALL, on the next edge and in any state, force state HOLD, hold counter 0, rst_out all-ones, rdy_out=0, done_out=0, timeout_out=0, run_cnt=0; rst_in has priority over every other input.
REQ-027 First edge with rst_in=0 SHALL count as hold cycle 1.

Verification (defaults unless stated)
REQ-028 rst_in high 3 edges then low -> rst_out=4'b1111 through edge 24, 4'b1110 after edge 25, 4'b1100 after 27, 4'b1000 after 29, 4'b0000 and rdy_out=1 after 31.
REQ-029 sw_rst_req pulsed when run_cnt=10 -> next edge rst_out=4'b1111, rdy_out=0, run_cnt=0; releases repeat 25/27/29/31 edges later.
REQ-030 halt_in pulsed when run_cnt=100 -> done_out=1, run_cnt stays 100, rst_out=4'b0000 indefinitely; later halt_in pulses change nothing.
REQ-031 TIMEOUT=50, no halt -> after 50th RUN edge timeout_out=1, done_out=1, run_cnt=50, rst_out=4'b1111; with halt_in on that same edge instead -> timeout_out=0, run_cnt=49.
REQ-032 rst_in asserted when rst_out=4'b1100 -> next edge rst_out=4'b1111; sw_rst_req and halt_in together in RUN -> HOLD, done_out=0.
REQ-033 STAGGER=0, CHANNELS=1, HOLD_CYCLES=1 -> rst_out=0 and rdy_out=1 after first edge with rst_in=0.
